// File: rtl/control_wall.sv
// rtl/control_wall.sv - Wall sprite sequencer: erase, move, redraw and score steps paced by a frame divider.
module control_wall #(
  parameter int FRAME_DIV  = 833333,
  parameter int WALL_WIDTH = 10,
  parameter int SCREEN_H   = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic       game_over,
  input  logic       wall_passed,
  output logic [1:0] alu_select,
  output logic       alu_en,
  output logic       plot,
  output logic [3:0] off_x,
  output logic [6:0] off_y,
  output logic       busy,
  output logic       overrun
);

  localparam int FW = ($clog2(FRAME_DIV) > 0) ? $clog2(FRAME_DIV) : 1;
  localparam logic [3:0]    X_LAST   = 4'(WALL_WIDTH - 1);
  localparam logic [6:0]    Y_LAST   = 7'(SCREEN_H - 1);
  localparam logic [FW-1:0] CNT_LAST = FW'(FRAME_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_DEL, S_UPD, S_DRAW, S_SCORE, S_INIT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [FW-1:0] r_frame_cnt;
  logic [3:0]    r_off_x;
  logic [6:0]    r_off_y;
  logic [1:0]    r_alu_sel;
  logic          r_pending;
  logic          r_overrun;
  logic          w_sweep;
  logic          w_last;
  logic          w_tick;
  logic          w_busy;

  assign w_sweep = (r_state == S_DEL) || (r_state == S_DRAW) || (r_state == S_INIT);
  assign w_last  = (r_off_x == X_LAST) && (r_off_y == Y_LAST);
  assign w_tick  = (r_state != S_IDLE) && (r_frame_cnt == CNT_LAST);
  assign w_busy  = (r_state != S_IDLE) && (r_state != S_WAIT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (go) w_next = S_INIT;
      S_INIT:  if (w_last) w_next = S_WAIT;
      S_WAIT: begin
        if (game_over)                  w_next = S_IDLE;
        else if (w_tick || r_pending)   w_next = S_DEL;
      end
      S_DEL:   if (w_last) w_next = S_UPD;
      S_UPD:   w_next = S_DRAW;
      S_DRAW:  if (w_last) w_next = wall_passed ? S_SCORE : S_WAIT;
      S_SCORE: w_next = S_WAIT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Select is registered from the next state so it holds its last value in IDLE/WAIT.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_alu_sel <= 2'd0;
    end else begin
      case (w_next)
        S_DEL:          r_alu_sel <= 2'd1;
        S_UPD:          r_alu_sel <= 2'd0;
        S_DRAW, S_INIT: r_alu_sel <= 2'd2;
        S_SCORE:        r_alu_sel <= 2'd3;
        default:        r_alu_sel <= r_alu_sel;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_off_x <= 4'd0;
      r_off_y <= 7'd0;
    end else if (w_sweep) begin
      if (r_off_x == X_LAST) begin
        r_off_x <= 4'd0;
        r_off_y <= (r_off_y == Y_LAST) ? 7'd0 : r_off_y + 7'd1;
      end else begin
        r_off_x <= r_off_x + 4'd1;
      end
    end
  end

  // Clearing on the way into IDLE keeps the count at 0 for the whole IDLE stay.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_frame_cnt <= '0;
    end else if (r_state == S_IDLE || w_next == S_IDLE || w_tick) begin
      r_frame_cnt <= '0;
    end else begin
      r_frame_cnt <= r_frame_cnt + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_next == S_IDLE) begin
      r_pending <= 1'b0;
    end else if (r_state == S_WAIT) begin
      r_pending <= 1'b0;
      if (w_tick && r_pending) r_overrun <= 1'b1;
    end else if (w_busy && w_tick) begin
      if (r_pending) r_overrun <= 1'b1;
      else           r_pending <= 1'b1;
    end
  end

  assign alu_select = r_alu_sel;
  assign alu_en     = (r_state == S_UPD) || (r_state == S_SCORE);
  assign plot       = w_sweep;
  assign off_x      = r_off_x;
  assign off_y      = r_off_y;
  assign busy       = w_busy;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_control_wall.sv
// tb/tb_control_wall.sv - Directed bench for control_wall: sweeps, step sequence, score, game over, reset, overrun.
module tb_control_wall;

  logic       clk = 1'b0;
  logic       resetn, go, game_over, wall_passed;
  logic [1:0] alu_select, o_alu_select;
  logic       alu_en, plot, busy, overrun;
  logic       o_alu_en, o_plot, o_busy, o_overrun;
  logic [3:0] off_x, o_off_x;
  logic [6:0] off_y, o_off_y;
  int         n_assert = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  control_wall #(.FRAME_DIV(3000), .WALL_WIDTH(10), .SCREEN_H(120)) u_dut (
    .clk(clk), .resetn(resetn), .go(go), .game_over(game_over), .wall_passed(wall_passed),
    .alu_select(alu_select), .alu_en(alu_en), .plot(plot), .off_x(off_x), .off_y(off_y),
    .busy(busy), .overrun(overrun)
  );

  control_wall #(.FRAME_DIV(1000), .WALL_WIDTH(10), .SCREEN_H(120)) u_ovr (
    .clk(clk), .resetn(resetn), .go(go), .game_over(game_over), .wall_passed(wall_passed),
    .alu_select(o_alu_select), .alu_en(o_alu_en), .plot(o_plot), .off_x(o_off_x), .off_y(o_off_y),
    .busy(o_busy), .overrun(o_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first INIT_DRAW cycle.
  task automatic start_game();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  // Checks one full sweep starting at the current cycle; returns on the cycle after it.
  task automatic run_sweep(input string tag, input logic [1:0] sel, input logic wp_early,
                           input logic wp_last, input int go_raise);
    int bad = 0;
    for (int i = 0; i < 1200; i++) begin
      wall_passed = (i == 1199) ? wp_last : wp_early;
      if (i == go_raise) game_over = 1'b1;
      if (plot !== 1'b1 || alu_select !== sel || alu_en !== 1'b0 || busy !== 1'b1 ||
          off_x !== 4'(i % 10) || off_y !== 7'(i / 10)) bad++;
      @(negedge clk);
    end
    wall_passed = 1'b0;
    chk(tag, bad, 0);
  endtask

  initial begin
    int cnt;
    resetn = 1'b0; go = 1'b0; game_over = 1'b0; wall_passed = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {alu_select, alu_en, plot, off_x, off_y, busy, overrun}, 0);
    resetn = 1'b1;
    @(negedge clk);

    start_game();
    chk("init_first_xy", {off_y, off_x}, 0);
    chk("init_first_sel", alu_select, 2);
    run_sweep("init_sweep", 2'd2, 1'b0, 1'b0, -1);
    chk("init_done_busy", busy, 0);
    chk("init_done_plot", plot, 0);
    chk("wait_sel_hold", alu_select, 2);
    repeat (1799) @(negedge clk);
    chk("pre_tick_plot", plot, 0);
    @(negedge clk);
    chk("del1_start_sel", alu_select, 1);
    run_sweep("del1_sweep", 2'd1, 1'b0, 1'b0, -1);
    chk("upd1_en", alu_en, 1);
    chk("upd1_sel", alu_select, 0);
    chk("upd1_plot", plot, 0);
    chk("upd1_busy", busy, 1);
    @(negedge clk);
    run_sweep("draw1_sweep", 2'd2, 1'b1, 1'b0, -1);
    chk("noscore_busy", busy, 0);
    chk("noscore_en", alu_en, 0);
    chk("noscore_sel", alu_select, 2);

    repeat (599) @(negedge clk);
    run_sweep("del2_sweep", 2'd1, 1'b0, 1'b0, -1);
    chk("upd2_en", alu_en, 1);
    @(negedge clk);
    run_sweep("draw2_sweep", 2'd2, 1'b0, 1'b1, -1);
    chk("score_sel", alu_select, 3);
    chk("score_en", alu_en, 1);
    chk("score_plot", plot, 0);
    @(negedge clk);
    chk("post_score_busy", busy, 0);
    chk("post_score_en", alu_en, 0);
    chk("post_score_sel", alu_select, 3);

    repeat (598) @(negedge clk);
    run_sweep("del3_gameover_sweep", 2'd1, 1'b0, 1'b0, 500);
    chk("upd3_en", alu_en, 1);
    @(negedge clk);
    run_sweep("draw3_sweep", 2'd2, 1'b0, 1'b0, -1);
    chk("gameover_busy", busy, 0);
    cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      if (plot !== 1'b0 || busy !== 1'b0 || alu_en !== 1'b0) cnt++;
      @(negedge clk);
    end
    chk("gameover_idle_quiet", cnt, 0);
    chk("idle_sel_hold", alu_select, 2);
    game_over = 1'b0;

    start_game();
    run_sweep("init2_sweep", 2'd2, 1'b0, 1'b0, -1);
    repeat (1799) @(negedge clk);
    game_over = 1'b1;
    @(negedge clk);
    game_over = 1'b0;
    chk("gameover_tick_plot", plot, 0);
    chk("gameover_tick_busy", busy, 0);
    cnt = 0;
    for (int i = 0; i < 3100; i++) begin
      if (plot !== 1'b0 || busy !== 1'b0) cnt++;
      @(negedge clk);
    end
    chk("gameover_tick_idle", cnt, 0);

    start_game();
    repeat (4806) @(negedge clk);
    chk("middraw_xy", {off_y, off_x}, {7'd60, 4'd5});
    chk("middraw_plot", plot, 1);
    resetn = 1'b0;
    #1;
    chk("async_rst_outs", {alu_select, alu_en, plot, off_x, off_y, busy, overrun}, 0);
    chk("async_rst_plot", plot, 0);
    @(negedge clk);
    resetn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if ({alu_select, alu_en, plot, off_x, off_y, busy, overrun} !== 17'd0) cnt++;
      @(negedge clk);
    end
    chk("post_rst_quiet", cnt, 0);

    start_game();
    repeat (1200) @(negedge clk);
    chk("ovr_wait_busy", o_busy, 0);
    chk("ovr_wait_en", o_alu_en, 0);
    @(negedge clk);
    chk("ovr_pending_del_plot", o_plot, 1);
    chk("ovr_pending_del_sel", o_alu_select, 1);
    chk("ovr_pending_del_xy", {o_off_y, o_off_x}, 0);
    repeat (1798) @(negedge clk);
    chk("ovr_before", o_overrun, 0);
    @(negedge clk);
    chk("ovr_set", o_overrun, 1);
    cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if (o_overrun !== 1'b1) cnt++;
      @(negedge clk);
    end
    chk("ovr_sticky", cnt, 0);
    resetn = 1'b0;
    #1;
    chk("ovr_rst_clear", o_overrun, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
